// File: rtl/bidi_bus_ctrl.sv
// Bidirectional shared-bus controller: arbitrates level write/read requests onto one
// tristate pad bus and inserts released turnaround cycles on every direction change.
module bidi_bus_ctrl #(
  parameter int DWIDTH    = 8,
  parameter int TA_CYC    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] bus_t,
  output logic [DWIDTH-1:0] bus_i,
  input  logic [DWIDTH-1:0] bus_o,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE_RX, IDLE_TX, TURN, WRITE, READ} state_t;

  localparam logic [3:0] TA_LOAD   = 4'(TA_CYC - 1);
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t            state_q;
  logic              turn_wr_q;
  logic [3:0]        ta_cnt_q;
  logic [3:0]        burst_cnt_q;
  logic [3:0]        burst_cnt_d;
  logic              bus_t_q;
  logic [DWIDTH-1:0] bus_i_q;
  logic [DWIDTH-1:0] rd_data_q;
  logic              wr_ack_q;
  logic              rd_ack_q;
  logic              busy_q;

  logic idle;
  logic in_tx;
  logic wr_pend;
  logic rd_pend;
  logic same_pend;
  logic opp_pend;
  logic rest;
  logic grant_same;
  logic grant_opp;
  logic grant_wr;
  logic grant_rd;

  always_comb begin
    idle        = (state_q == IDLE_RX) || (state_q == IDLE_TX);
    in_tx       = (state_q == IDLE_TX);
    wr_pend     = wr_req & ~wr_ack_q;
    rd_pend     = rd_req & ~rd_ack_q;
    same_pend   = in_tx ? wr_pend : rd_pend;
    opp_pend    = in_tx ? rd_pend : wr_pend;
    // The rd_ack cycle grants nothing, so a read burst is not broken by the masked rd_req.
    rest        = (state_q == IDLE_RX) && rd_ack_q;
    grant_same  = 1'b0;
    grant_opp   = 1'b0;
    burst_cnt_d = burst_cnt_q;
    if (idle && !rest) begin
      burst_cnt_d = '0;
      if (same_pend && !(opp_pend && (burst_cnt_q == BURST_LIM))) begin
        grant_same = 1'b1;
        if (opp_pend) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end else if (opp_pend) begin
        grant_opp = 1'b1;
      end
    end else if (rest && !opp_pend) begin
      burst_cnt_d = '0;
    end
    grant_wr = in_tx ? grant_same : grant_opp;
    grant_rd = in_tx ? grant_opp  : grant_same;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE_RX;
      turn_wr_q   <= 1'b0;
      ta_cnt_q    <= '0;
      burst_cnt_q <= '0;
      bus_t_q     <= 1'b1;
      bus_i_q     <= '0;
      rd_data_q   <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      burst_cnt_q <= burst_cnt_d;
      case (state_q)
        IDLE_RX, IDLE_TX: begin
          if (grant_wr) begin
            bus_i_q   <= wr_data;
            turn_wr_q <= 1'b1;
            busy_q    <= 1'b1;
            if (in_tx) begin
              state_q  <= WRITE;
              wr_ack_q <= 1'b1;
            end else begin
              state_q  <= TURN;
              ta_cnt_q <= TA_LOAD;
            end
          end else if (grant_rd) begin
            turn_wr_q <= 1'b0;
            busy_q    <= 1'b1;
            bus_t_q   <= 1'b1;
            if (in_tx) begin
              state_q  <= TURN;
              ta_cnt_q <= TA_LOAD;
            end else begin
              state_q <= READ;
            end
          end
        end
        TURN: begin
          if (ta_cnt_q == 4'd0) begin
            if (turn_wr_q) begin
              state_q  <= WRITE;
              bus_t_q  <= 1'b0;
              wr_ack_q <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end else begin
            ta_cnt_q <= ta_cnt_q - 4'd1;
          end
        end
        WRITE: begin
          state_q <= IDLE_TX;
          busy_q  <= 1'b0;
        end
        READ: begin
          state_q   <= IDLE_RX;
          rd_data_q <= bus_o;
          rd_ack_q  <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE_RX;
          bus_t_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // One tristate flop fans out to every pad so the bits can never disagree.
  for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_bus_t
    assign bus_t[gi] = bus_t_q;
  end

  assign bus_i   = bus_i_q;
  assign rd_data = rd_data_q;
  assign wr_ack  = wr_ack_q;
  assign rd_ack  = rd_ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bidi_bus_ctrl.sv
// Self-checking bench for bidi_bus_ctrl: directed bus scenarios plus randomized requesters,
// checked every cycle against a transaction-schedule reference model.
module tb_bidi_bus_ctrl;

  localparam int DW = 8;
  localparam int TA = 2;
  localparam int MB = 4;

  logic          clk;
  logic          reset;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] bus_t;
  logic [DW-1:0] bus_i;
  logic [DW-1:0] bus_o;
  logic          busy;

  bidi_bus_ctrl #(.DWIDTH(DW), .TA_CYC(TA), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .bus_t(bus_t), .bus_i(bus_i), .bus_o(bus_o), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: each grant schedules the expected per-cycle bus picture in a queue.
  typedef struct packed {
    logic          t;
    logic [DW-1:0] bi;
    logic          wa;
    logic          ra;
    logic          bsy;
    logic          is_rd;
  } rec_t;

  rec_t          sched[$];
  rec_t          cur;
  logic [DW-1:0] last_wr;
  logic [DW-1:0] rd_exp;
  int            burst;
  bit            dir_tx;

  function automatic rec_t mk(input logic t, input logic [DW-1:0] bi, input logic wa,
                              input logic ra, input logic bsy, input logic is_rd);
    rec_t r;
    r.t = t; r.bi = bi; r.wa = wa; r.ra = ra; r.bsy = bsy; r.is_rd = is_rd;
    return r;
  endfunction

  task automatic model_reset();
    sched.delete();
    last_wr = '0;
    rd_exp  = '0;
    burst   = 0;
    dir_tx  = 0;
    cur     = mk(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_edge();
    bit w, r, same, opp, gw, gr;
    if (cur.is_rd) rd_exp = bus_o;
    if (sched.size() > 0) begin
      cur = sched.pop_front();
      return;
    end
    w  = wr_req && !cur.wa;
    r  = rd_req && !cur.ra;
    gw = 0;
    gr = 0;
    if (cur.ra) begin
      if (!w) burst = 0;
    end else begin
      same = dir_tx ? w : r;
      opp  = dir_tx ? r : w;
      if (same && !(opp && burst == MB)) begin
        burst = opp ? burst + 1 : 0;
        if (dir_tx) gw = 1; else gr = 1;
      end else if (opp) begin
        burst = 0;
        if (dir_tx) gr = 1; else gw = 1;
      end else begin
        burst = 0;
      end
    end
    if (gw) begin
      last_wr = wr_data;
      if (!dir_tx) repeat (TA) sched.push_back(mk(1'b1, last_wr, 1'b0, 1'b0, 1'b1, 1'b0));
      sched.push_back(mk(1'b0, last_wr, 1'b1, 1'b0, 1'b1, 1'b0));
      sched.push_back(mk(1'b0, last_wr, 1'b0, 1'b0, 1'b0, 1'b0));
      dir_tx = 1;
    end else if (gr) begin
      if (dir_tx) repeat (TA) sched.push_back(mk(1'b1, last_wr, 1'b0, 1'b0, 1'b1, 1'b0));
      sched.push_back(mk(1'b1, last_wr, 1'b0, 1'b0, 1'b1, 1'b1));
      sched.push_back(mk(1'b1, last_wr, 1'b0, 1'b1, 1'b0, 1'b0));
      dir_tx = 0;
    end else begin
      sched.push_back(mk(!dir_tx, last_wr, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    cur = sched.pop_front();
  endtask

  task automatic check_cycle();
    chk("bus_t", bus_t, cur.t ? 32'hFF : 32'h00);
    if (!cur.t) chk("bus_i", bus_i, cur.bi);
    chk("wr_ack", wr_ack, cur.wa);
    chk("rd_ack", rd_ack, cur.ra);
    chk("busy", busy, cur.bsy);
    chk("rd_data", rd_data, rd_exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic tick_until(input bit is_wr, input int max, output int n);
    bit    ok;
    string tag;
    n  = 0;
    ok = 0;
    while (!ok && n < max) begin
      tick();
      n++;
      if (is_wr ? wr_ack : rd_ack) ok = 1;
    end
    tag = is_wr ? "wr_ack_seen" : "rd_ack_seen";
    chk(tag, ok, 1);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_bus_t", bus_t, 32'hFF);
    chk("rst_bus_i", bus_i, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  bit wr_drop_next = 0;
  bit rd_drop_next = 0;

  task automatic agent(input int p);
    if (wr_drop_next) begin
      wr_req = 1'b0; wr_drop_next = 0;
    end else if (wr_req && wr_ack) begin
      if ($urandom_range(1) == 0) wr_req = 1'b0; else wr_drop_next = 1;
    end else if (!wr_req && $urandom_range(99) < p) begin
      wr_req = 1'b1;
    end
    if (rd_drop_next) begin
      rd_req = 1'b0; rd_drop_next = 0;
    end else if (rd_req && rd_ack) begin
      if ($urandom_range(1) == 0) rd_req = 1'b0; else rd_drop_next = 1;
    end else if (!rd_req && $urandom_range(99) < p) begin
      rd_req = 1'b1;
    end
    wr_data = DW'($urandom);
    bus_o   = DW'($urandom);
    if ($urandom_range(149) == 0) async_reset();
  endtask

  function automatic bit burst_exp_w(input int i);
    if (i < MB) return 1'b1;
    return (((i - MB) / (MB + 1)) % 2) == 1;
  endfunction

  initial begin
    int n;
    int acks;
    int got_n;
    int cyc;
    int probs[3];
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0; bus_o = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_bus_t", bus_t, 32'hFF);
    chk("reset_bus_i", bus_i, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_acks", {wr_ack, rd_ack}, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;

    // First write from IDLE_RX: full turnaround, data captured at the grant edge.
    wr_data = 8'hA5; wr_req = 1'b1;
    tick();
    chk("w1_turn_bus_t", bus_t, 32'hFF);
    wr_data = 8'h00;
    tick_until(1, 10, n);
    chk("w1_latency", n, TA);
    chk("w1_bus_t", bus_t, 32'h00);
    chk("w1_bus_i", bus_i, 32'hA5);
    wr_req = 1'b0;
    tick();
    chk("w1_hold_bus_i", bus_i, 32'hA5);
    chk("w1_hold_bus_t", bus_t, 32'h00);

    // Back-to-back writes from IDLE_TX: no turnaround.
    wr_data = 8'h11; wr_req = 1'b1;
    tick_until(1, 10, n);
    chk("b2b_11_latency", n, 1);
    chk("b2b_11_bus_i", bus_i, 32'h11);
    wr_data = 8'h22;
    tick_until(1, 10, n);
    chk("b2b_22_latency", n, 2);
    chk("b2b_22_bus_i", bus_i, 32'h22);
    wr_data = 8'h3C;
    tick_until(1, 10, n);
    chk("w3c_bus_i", bus_i, 32'h3C);

    // Write then read: turnaround before READ, data sampled from the pads.
    wr_req = 1'b0; rd_req = 1'b1; bus_o = 8'hC3;
    tick_until(0, 20, n);
    chk("rd_latency", n, TA + 3);
    chk("rd_data_c3", rd_data, 32'hC3);
    chk("rd_bus_t", bus_t, 32'hFF);

    // rd_req still high during the rd_ack cycle must not start a second read.
    acks = 0;
    tick();
    if (rd_ack) acks++;
    rd_req = 1'b0;
    repeat (6) begin
      tick();
      if (rd_ack) acks++;
    end
    chk("rd_single_ack", acks, 0);

    // Reset on the second TURN cycle of a write aborts it; held request restarts.
    wr_data = 8'h5A; wr_req = 1'b1;
    tick();
    tick();
    chk("abort_turn2_busy", busy, 1);
    async_reset();
    chk("abort_no_wr_ack", wr_ack, 0);
    tick_until(1, 10, n);
    chk("restart_latency", n, TA + 1);
    chk("restart_bus_i", bus_i, 32'h5A);

    // Both requests held continuously from IDLE_TX: bounded bursts alternate.
    rd_req = 1'b1;
    got_n = 0;
    cyc = 0;
    while (got_n < 19 && cyc < 400) begin
      tick();
      cyc++;
      if (wr_ack || rd_ack) begin
        chk($sformatf("burst_grant%0d_is_wr", got_n), wr_ack, burst_exp_w(got_n));
        got_n++;
      end
    end
    chk("burst_grant_count", got_n, 19);

    // Randomized requesters at light, medium and heavy load.
    probs[0] = 20; probs[1] = 60; probs[2] = 95;
    for (int ph = 0; ph < 3; ph++) begin
      repeat (500) begin
        agent(probs[ph]);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/bidi_bus_ctrl.md
BIDI_BUS_CTRL -- requirements
Module: bidi_bus_ctrl

Interface
REQ-001 Parameter DWIDTH, default 8: width of the shared bidirectional data bus.
REQ-002 Parameter TA_CYC, default 2, legal range 1..15: number of bus-released turnaround cycles inserted on every direction change.
REQ-003 Parameter MAX_BURST, default 4, legal range 1..15: maximum consecutive same-direction grants while the opposite request is pending.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 wr_req  in  1  write request; level, held until wr_ack.
REQ-008 wr_data  in  DWIDTH  write data; captured when the write is granted.
REQ-009 wr_ack  out  1  one-cycle pulse; the bus is driven with the captured data in this cycle.
REQ-010 rd_req  in  1  read request; level, held until rd_ack.
REQ-011 rd_ack  out  1  one-cycle pulse; rd_data is valid in this cycle.
REQ-012 rd_data  out  DWIDTH  sampled bus value; holds until the next read.
REQ-013 bus_t  out  DWIDTH  per-bit tristate control to the pad cells (1 = released, 0 = driven).
REQ-014 bus_i  out  DWIDTH  value driven onto the pads when bus_t=0.
REQ-015 bus_o  in  DWIDTH  value read back from the pads.
REQ-016 busy  out  1  high in any state other than IDLE_RX or IDLE_TX.

Function
REQ-017 All outputs SHALL be registered; all bus_t bits SHALL always be equal.
REQ-018 States: IDLE_RX (bus_t=1), IDLE_TX (bus_t=0, bus_i holds the last write value), TURN (bus_t=1, counting), WRITE (bus_t=0, wr_ack=1), READ (bus_t=1).
REQ-019 IDLE_RX + granted write: capture wr_data -> TURN for exactly TA_CYC cycles -> WRITE for 1 cycle -> IDLE_TX.
REQ-020 IDLE_TX + granted write: capture wr_data -> WRITE on the next cycle, with no turnaround.
REQ-021 IDLE_TX + granted read: bus_t=1 on the next cycle -> TURN for TA_CYC cycles -> READ for 1 cycle -> IDLE_RX.
REQ-022 IDLE_RX + granted read: -> READ on the next cycle.
REQ-023 READ: rd_data <= bus_o on the edge leaving READ; rd_ack=1 for exactly the following cycle.
REQ-024 A request SHALL be ignored in any cycle where its own ack is high, so a requester that drops req after seeing ack is never served twice.
REQ-025 Simultaneous wr_req and rd_req: grant the current bus direction (IDLE_TX prefers write, IDLE_RX prefers read).
REQ-026 burst_cnt SHALL increment on each same-direction grant while the opposite request is pending, and clear on a direction change or when the opposite request is absent.
REQ-027 When burst_cnt = MAX_BURST and the opposite request is pending, the opposite direction SHALL be granted.
REQ-028 Requests SHALL only be evaluated in IDLE_RX/IDLE_TX; changes to wr_req/rd_req during TURN, WRITE or READ SHALL not alter the sequence in progress.
REQ-029 The turnaround counter SHALL be 4 bits, load TA_CYC-1 on entry to TURN, and exit TURN at zero; it SHALL never wrap.
REQ-030 bus_t=0 and bus_t=1 SHALL never be driven toward opposite directions in adjacent cycles without a TURN state between them.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE_RX, bus_t=all 1, bus_i=0, rd_data=0, wr_ack=0, rd_ack=0, busy=0, burst_cnt=0, and turnaround counter=0.
REQ-032 Reset asserted mid-operation (TURN/WRITE/READ) SHALL abort the operation with no ack issued; requests still high after reset deassertion are served as new requests.
REQ-033 Release from reset SHALL be synchronous to clk; the first request is evaluated at the first rising edge with reset low.

Verification
REQ-034 Reset, then wr_req=1 with wr_data=0xA5 (TA_CYC=2) -> bus_t=0xFF for 2 TURN cycles, then 1 cycle with bus_t=0x00, bus_i=0xA5, wr_ack=1; bus_i stays 0xA5 afterwards.
REQ-035 Back-to-back writes 0x11 then 0x22 from IDLE_TX -> no TURN cycles; wr_ack pulses with bus_i=0x11 then 0x22, bus_t stays 0x00.
REQ-036 Write 0x3C followed by a read with bus_o=0xC3 -> bus_t=0xFF, 2 TURN cycles, READ, then rd_ack=1 with rd_data=0xC3; the block ends in IDLE_RX.
REQ-037 wr_req and rd_req held continuously (MAX_BURST=4) from IDLE_TX -> 4 writes, then 1 read, then 4 reads, then 1 write, alternating; no grant starves.
REQ-038 Reset asserted on the 2nd TURN cycle of a write -> bus_t=0xFF immediately, no wr_ack; after release, the held wr_req restarts with a full 2-cycle TURN.
REQ-039 Requester holds rd_req one cycle beyond rd_ack -> exactly one rd_ack is produced (REQ-024).
